// File: rtl/vga_mem_ctrl.sv
// vga_mem_ctrl: once per video line, reads one memory row into a shadow register and
// serialises it LSB-first into a 1-bit pixel stream. Optional macro VGA_MEM_CTRL_LINE_DOUBLE_EN.
module vga_mem_ctrl #(
  parameter int unsigned RAM_WIDTH      = 72,
  parameter int unsigned RAM_DEPTH      = 480,
  parameter int unsigned PIXELS_PER_BIT = 9
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         frame_start_in,
  input  logic                         line_start_in,
  input  logic                         pixel_en_in,
  output logic [$clog2(RAM_DEPTH)-1:0] mem_addr_out,
  output logic                         mem_re_out,
  input  logic [RAM_WIDTH-1:0]         mem_data_in,
  output logic                         pixel_out,
  output logic                         line_ready_out,
  output logic                         underrun_out
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned BW = $clog2(RAM_WIDTH + 1);
  localparam int unsigned SW = (PIXELS_PER_BIT > 1) ? $clog2(PIXELS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, READY, SHIFT} state_t;

  state_t               state, state_next;
  logic [RAM_WIDTH-1:0] shadow;
  logic [RAM_WIDTH-1:0] shifted;
  logic [BW-1:0]        bit_idx;
  logic [SW-1:0]        sub_cnt;
  logic                 row_adv;
  logic                 shift_c;
  logic                 pix_c;
  logic                 under_c;
  logic [AW-1:0]        row_inc;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, line advance and pixel selection
  always_comb begin
    state_next = state;
    row_adv    = 1'b0;
    shift_c    = 1'b0;
    pix_c      = 1'b0;
    under_c    = 1'b0;
    shifted    = shadow >> bit_idx;
    case (state)
      IDLE: begin
        under_c = pixel_en_in;
        if (line_start_in) state_next = FETCH;
      end
      FETCH: begin
        under_c    = pixel_en_in;
        state_next = READY;
      end
      READY, SHIFT: begin
        if (line_start_in) begin
          row_adv    = 1'b1;
          state_next = FETCH;
        end else if (pixel_en_in) begin
          shift_c    = 1'b1;
          pix_c      = (bit_idx < BW'(RAM_WIDTH)) ? shifted[0] : 1'b0;
          state_next = SHIFT;
        end else if (state == SHIFT) begin
          row_adv    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign row_inc = (mem_addr_out == AW'(RAM_DEPTH - 1)) ? '0 : mem_addr_out + AW'(1);

  // Row counter; frame start has priority so a coincident fetch uses row 0
`ifdef VGA_MEM_CTRL_LINE_DOUBLE_EN
  logic phase;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_addr_out <= '0;
      phase        <= 1'b0;
    end else if (frame_start_in) begin
      mem_addr_out <= '0;
      phase        <= 1'b0;
    end else if (row_adv) begin
      phase <= ~phase;
      if (phase) mem_addr_out <= row_inc;
    end
  end
`else
  always_ff @(posedge clk_in) begin
    if (rst_in)              mem_addr_out <= '0;
    else if (frame_start_in) mem_addr_out <= '0;
    else if (row_adv)        mem_addr_out <= row_inc;
  end
`endif

  // Shadow register, bit/sub-pixel counters and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow         <= '0;
      bit_idx        <= '0;
      sub_cnt        <= '0;
      mem_re_out     <= 1'b0;
      line_ready_out <= 1'b0;
      pixel_out      <= 1'b0;
      underrun_out   <= 1'b0;
    end else begin
      mem_re_out     <= (state_next == FETCH);
      line_ready_out <= (state_next == READY);
      pixel_out      <= pix_c;
      underrun_out   <= (underrun_out & ~frame_start_in) | under_c;
      if (state == FETCH) begin
        shadow  <= mem_data_in;
        bit_idx <= '0;
        sub_cnt <= '0;
      end else if (shift_c) begin
        if (sub_cnt == SW'(PIXELS_PER_BIT - 1)) begin
          sub_cnt <= '0;
          if (bit_idx != BW'(RAM_WIDTH)) bit_idx <= bit_idx + BW'(1);
        end else begin
          sub_cnt <= sub_cnt + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_mem_ctrl.sv
// Testbench for vga_mem_ctrl: behavioural row/pixel model feeding address and pixel scoreboards.
module tb_vga_mem_ctrl;

  localparam int unsigned RAM_WIDTH = 72;
  localparam int unsigned RAM_DEPTH = 480;
  localparam int unsigned PPB       = 9;
  localparam int unsigned AW        = $clog2(RAM_DEPTH);

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b1;
  logic                 frame_start_in = 1'b0;
  logic                 line_start_in = 1'b0;
  logic                 pixel_en_in = 1'b0;
  logic [AW-1:0]        mem_addr_out;
  logic                 mem_re_out;
  logic [RAM_WIDTH-1:0] mem_data_in;
  logic                 pixel_out;
  logic                 line_ready_out;
  logic                 underrun_out;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] cur_word;
  logic                 exp_pix_q [$];
  int                   exp_addr_q [$];
  int                   tests = 0;
  int                   fails = 0;
  int                   exp_row = 0;
  int                   reads = 0;
`ifdef VGA_MEM_CTRL_LINE_DOUBLE_EN
  bit                   exp_phase = 1'b0;
`endif

  vga_mem_ctrl #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .PIXELS_PER_BIT(PPB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .line_start_in(line_start_in), .pixel_en_in(pixel_en_in),
    .mem_addr_out(mem_addr_out), .mem_re_out(mem_re_out), .mem_data_in(mem_data_in),
    .pixel_out(pixel_out), .line_ready_out(line_ready_out), .underrun_out(underrun_out)
  );

  always #5 clk_in = ~clk_in;

  assign mem_data_in = mem_re_out ? mem[mem_addr_out] : '0;

  always @(posedge clk_in) if (mem_re_out) reads <= reads + 1;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_frame();
    exp_row = 0;
`ifdef VGA_MEM_CTRL_LINE_DOUBLE_EN
    exp_phase = 1'b0;
`endif
  endtask

  task automatic model_complete();
`ifdef VGA_MEM_CTRL_LINE_DOUBLE_EN
    exp_phase = ~exp_phase;
    if (!exp_phase) exp_row = (exp_row == RAM_DEPTH - 1) ? 0 : exp_row + 1;
`else
    exp_row = (exp_row == RAM_DEPTH - 1) ? 0 : exp_row + 1;
`endif
  endtask

  // Line start pulse (optionally with frame start / pixel enable), fetch and ready checks
  task automatic start_line(input bit with_fs, input bit pen);
    int a;
    if (with_fs) model_frame();
    exp_addr_q.push_back(exp_row);
    line_start_in  = 1'b1;
    frame_start_in = with_fs;
    pixel_en_in    = pen;
    step();
    line_start_in  = 1'b0;
    frame_start_in = 1'b0;
    pixel_en_in    = 1'b0;
    a = exp_addr_q.pop_front();
    tests++;
    if (mem_re_out !== 1'b1 || mem_addr_out !== AW'(a)) begin
      fails++;
      $display("FAIL fetch: re=%b addr=%0d, required re=1 addr=%0d", mem_re_out, mem_addr_out, a);
    end
    cur_word = mem[a];
    step();
    tests++;
    if (line_ready_out !== 1'b1 || mem_re_out !== 1'b0) begin
      fails++;
      $display("FAIL ready: ready=%b re=%b, required ready=1 re=0", line_ready_out, mem_re_out);
    end
    step();
  endtask

  // Active pixels, optionally with a frame start at pixel fs_at; leaves pixel_en high
  task automatic drive_pixels(input int n, input int fs_at);
    int  r0;
    int  idx;
    logic e;
    logic got;
    r0 = reads;
    for (int k = 0; k < n; k++) begin
      idx = k / PPB;
      exp_pix_q.push_back((idx < RAM_WIDTH) ? cur_word[idx] : 1'b0);
      pixel_en_in    = 1'b1;
      frame_start_in = (k == fs_at);
      if (k == fs_at) model_frame();
      step();
      frame_start_in = 1'b0;
      e   = exp_pix_q.pop_front();
      got = pixel_out;
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL pixel %0d: got %b, required %b", k, got, e);
      end
    end
    tests++;
    if (reads != r0) begin
      fails++;
      $display("FAIL read_in_active: %0d reads, required 0", reads - r0);
    end
  endtask

  task automatic end_line();
    pixel_en_in = 1'b0;
    step();
    model_complete();
    tests++;
    if (pixel_out !== 1'b0 || line_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL end_line: pixel=%b ready=%b, required 0 0", pixel_out, line_ready_out);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    model_frame();
    tests++;
    if (mem_addr_out !== '0) begin fails++; $display("FAIL reset_addr: got %0d, required 0", mem_addr_out); end
    tests++;
    if (mem_re_out !== 1'b0) begin fails++; $display("FAIL reset_re: got %b, required 0", mem_re_out); end
    tests++;
    if (pixel_out !== 1'b0) begin fails++; $display("FAIL reset_pixel: got %b, required 0", pixel_out); end
    tests++;
    if (line_ready_out !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, required 0", line_ready_out); end
    tests++;
    if (underrun_out !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b, required 0", underrun_out); end
  endtask

  task automatic test_all_ones();
    start_line(1'b0, 1'b0);
    drive_pixels(640, -1);
    end_line();
    tests++;
    if (underrun_out !== 1'b0) begin fails++; $display("FAIL ones_underrun: got %b, required 0", underrun_out); end
  endtask

  task automatic test_single_bit();
    start_line(1'b0, 1'b0);
    drive_pixels(640, -1);
    end_line();
  endtask

  task automatic test_wrap();
    int  prev;
    int  guard;
    bit  wrapped;
    guard   = 0;
    wrapped = 1'b0;
    while (!wrapped && guard < 1000) begin
      prev = exp_row;
      start_line(1'b0, 1'b0);
      drive_pixels(4, -1);
      end_line();
      wrapped = (prev == RAM_DEPTH - 1) && (exp_row == 0);
      guard++;
    end
    tests++;
    if (!wrapped) begin fails++; $display("FAIL wrap_budget: %0d lines, required wrap", guard); end
    start_line(1'b0, 1'b0);
    drive_pixels(18, -1);
    end_line();
  endtask

  task automatic test_frame_restart();
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
    model_frame();
    start_line(1'b0, 1'b0);
    drive_pixels(10, -1);
    end_line();
    start_line(1'b0, 1'b0);
    drive_pixels(30, 12);
    end_line();
    start_line(1'b0, 1'b0);
    drive_pixels(10, -1);
    end_line();
  endtask

  task automatic test_underrun();
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
    model_frame();
    tests++;
    if (underrun_out !== 1'b0) begin fails++; $display("FAIL underrun_pre: got %b, required 0", underrun_out); end
    for (int k = 0; k < 3; k++) begin
      pixel_en_in = 1'b1;
      step();
      tests++;
      if (underrun_out !== 1'b1 || pixel_out !== 1'b0) begin
        fails++;
        $display("FAIL underrun_set: underrun=%b pixel=%b, required 1 0", underrun_out, pixel_out);
      end
    end
    pixel_en_in = 1'b0;
    step();
    tests++;
    if (line_ready_out !== 1'b0 || mem_re_out !== 1'b0) begin
      fails++;
      $display("FAIL underrun_state: ready=%b re=%b, required 0 0", line_ready_out, mem_re_out);
    end
    start_line(1'b0, 1'b0);
    drive_pixels(9, -1);
    end_line();
    tests++;
    if (underrun_out !== 1'b1) begin fails++; $display("FAIL underrun_hold: got %b, required 1", underrun_out); end
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
    model_frame();
    tests++;
    if (underrun_out !== 1'b0) begin fails++; $display("FAIL underrun_clear: got %b, required 0", underrun_out); end
  endtask

  task automatic test_abandon();
    start_line(1'b0, 1'b0);
    model_complete();
    start_line(1'b0, 1'b0);
    drive_pixels(15, -1);
    model_complete();
    start_line(1'b0, 1'b1);
    drive_pixels(20, -1);
    end_line();
    start_line(1'b0, 1'b0);
    drive_pixels(5, -1);
    end_line();
    tests++;
    if (underrun_out !== 1'b0) begin fails++; $display("FAIL abandon_underrun: got %b, required 0", underrun_out); end
  endtask

  task automatic test_same_cycle();
    start_line(1'b1, 1'b0);
    drive_pixels(9, -1);
    end_line();
  endtask

  task automatic test_fetch_ignore();
    line_start_in = 1'b1;
    step();
    tests++;
    if (mem_re_out !== 1'b1 || mem_addr_out !== AW'(exp_row)) begin
      fails++;
      $display("FAIL ign_fetch: re=%b addr=%0d, required re=1 addr=%0d", mem_re_out, mem_addr_out, exp_row);
    end
    cur_word = mem[exp_row];
    step();
    line_start_in = 1'b0;
    tests++;
    if (line_ready_out !== 1'b1 || mem_re_out !== 1'b0 || mem_addr_out !== AW'(exp_row)) begin
      fails++;
      $display("FAIL ign_ready: ready=%b re=%b addr=%0d, required 1 0 %0d",
               line_ready_out, mem_re_out, mem_addr_out, exp_row);
    end
    step();
    drive_pixels(20, -1);
    end_line();
  endtask

  task automatic test_reset_mid();
    start_line(1'b0, 1'b0);
    drive_pixels(20, -1);
    pixel_en_in = 1'b0;
    rst_in      = 1'b1;
    step();
    rst_in = 1'b0;
    model_frame();
    tests++;
    if (mem_addr_out !== '0 || line_ready_out !== 1'b0 || pixel_out !== 1'b0 || mem_re_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: addr=%0d ready=%b pixel=%b re=%b, required 0 0 0 0",
               mem_addr_out, line_ready_out, pixel_out, mem_re_out);
    end
    start_line(1'b0, 1'b0);
    drive_pixels(12, -1);
    end_line();
  endtask

  task automatic test_six_lines();
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
    model_frame();
    for (int l = 0; l < 6; l++) begin
      start_line(1'b0, 1'b0);
      drive_pixels(10, -1);
      end_line();
    end
  endtask

  initial begin
    for (int r = 0; r < RAM_DEPTH; r++) mem[r] = {$urandom(), $urandom(), $urandom()};
    mem[0] = '1;
    mem[1] = RAM_WIDTH'(1);
    test_reset();
    test_all_ones();
    test_single_bit();
    test_wrap();
    test_frame_restart();
    test_underrun();
    test_abandon();
    test_same_cycle();
    test_fetch_ignore();
    test_reset_mid();
    test_six_lines();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_mem_ctrl.md
# vga_mem_ctrl

Line-fetch controller for the VGA line memory (72-bit × 480-row pattern RAM). Once per active video line it issues a single-cycle read of the current row, latches the word into a shadow register, and serialises it into a 1-bit pixel stream that is aligned to the timing generator's active-pixel enable. It sits between the sync/timing generator and the memory, and is the memory's only reader.

## Interface
- `RAM_WIDTH`, 72: memory word width; bits per displayed line.
- `RAM_DEPTH`, 480: memory rows.
- `PIXELS_PER_BIT`, 9: consecutive pixels driven by each word bit.
- `clk_in` in 1: system/pixel clock.
- `rst_in` in 1: reset, synchronous and active-high.
- `frame_start_in` in 1: single-cycle pulse at start of frame (vertical blank).
- `line_start_in` in 1: single-cycle pulse at least 3 cycles before the first active pixel of each line.
- `pixel_en_in` in 1: high during active-video pixels of a line.
- `mem_addr_out` out $clog2(RAM_DEPTH): memory row address.
- `mem_re_out` out 1: memory read enable.
- `mem_data_in` in RAM_WIDTH: memory read data, combinational from address/re.
- `pixel_out` out 1: serialised pixel value, registered.
- `line_ready_out` out 1: shadow register holds a valid line, not yet started.
- `underrun_out` out 1: sticky flag for an active pixel requested with no line loaded.

## Operation
- State machine, states IDLE, FETCH, READY, SHIFT. Reset → IDLE.
- IDLE: `line_start_in` → FETCH.
- FETCH, exactly 1 cycle: `mem_re_out`=1, `mem_addr_out`=row. `mem_data_in` is captured into the shadow register at the end of the cycle. → READY.
- READY: `line_ready_out`=1. `pixel_en_in`=1 → SHIFT, and this cycle consumes pixel 0.
- SHIFT: each cycle with `pixel_en_in`=1 outputs bit[bit_idx], where bit 0 (LSB) is the leftmost pixel.
  - `sub_cnt` counts 0..PIXELS_PER_BIT-1. On wrap, `bit_idx` increments.
  - When `bit_idx` passes RAM_WIDTH-1, `pixel_out`=0 for the rest of the line.
  - `pixel_en_in`=0 → IDLE, and the line is complete.
- Row counter:
  - Increments on each line completion.
  - Wraps from RAM_DEPTH-1 to 0.
  - `frame_start_in` clears it to 0.
- `mem_re_out`=0 and `mem_addr_out`=row in every state except FETCH.
- Underrun: `pixel_en_in`=1 in IDLE or FETCH sets `underrun_out`. `pixel_out`=0 for that cycle and no state change is caused by it. `underrun_out` is cleared only by `frame_start_in` or reset.
- Boundary conditions:
  - `frame_start_in` and `line_start_in` in the same cycle: row=0 takes effect first, so the fetch uses row 0.
  - `line_start_in` during SHIFT or READY: the current line is abandoned, row increments, → FETCH.
  - `frame_start_in` mid-line: the row is cleared, the current line finishes from the shadow register, and the next completion increments row to 1. Completion still increments row even when the frame restarts during that line.
  - `line_start_in` during FETCH: ignored.
- Reset mid-operation: all state returns to reset values on the next edge, and the shadow register is cleared to 0.

## Timing
- Reset values:
  - state IDLE, row 0, `bit_idx` 0, `sub_cnt` 0.
  - `mem_addr_out` 0, `mem_re_out` 0, `pixel_out` 0.
  - `line_ready_out` 0, `underrun_out` 0.
- `line_start_in` at edge N → FETCH in cycle N+1, `mem_re_out` high for exactly that cycle.
- The shadow register is valid and `line_ready_out`=1 from cycle N+2.
- Pixel latency: `pixel_out` reflects the pixel sampled on the previous edge. Pixel k of a line appears 1 cycle after the k-th `pixel_en_in` high cycle.
- `pixel_out` returns to 0 one cycle after `pixel_en_in` falls.
- At most one memory read per line, and no read during active pixels.

## Configuration
- `VGA_MEM_CTRL_LINE_DOUBLE_EN` defined: each row is displayed on two consecutive lines. A 1-bit phase toggles on each line completion, and row increments only when the phase wraps to 0. `frame_start_in` clears the phase. The row is still fetched on every line.
- Not defined: row increments on every line completion, and no phase flop exists.

## Test plan
- Reset, then `line_start_in` pulse → one cycle with `mem_re_out`=1, addr=0. `line_ready_out`=1 from the following cycle.
- Row 0 = all ones, 640 `pixel_en_in` cycles → `pixel_out`=1 for pixels 0..639. `underrun_out`=0.
- Row 1 = 72'h1 (bit 0 only) → `pixel_out`=1 for pixels 0..8 and 0 for pixels 9..639. Next fetch uses addr 2.
- 480 lines, then a 481st line without `frame_start_in` → addr wraps 479 → 0. `frame_start_in` mid-frame → next fetch addr 0.
- `pixel_en_in` high with no preceding `line_start_in` → `underrun_out`=1 and `pixel_out`=0, held until `frame_start_in`.
- With `VGA_MEM_CTRL_LINE_DOUBLE_EN`: fetch addresses over 6 lines are 0,0,1,1,2,2.
